bai1_pio_poll_master: RTL and testbench

Avalon-MM read master that periodically polls the data register (offset 0) of a single-bit input PIO slave, debounces bit 0 of the returned word, and presents a clean level, one-cycle edge pulses and a rising-edge counter to local logic. It is the initiator for the PIO slave interface in the bai1 system. It sits on the same clock as the PIO, and the interconnect routes its requests to that slave.

---
 rtl/bai1_pio_pkg.sv | 14 +
 rtl/bai1_pio_debounce.sv | 57 +++++
 rtl/bai1_pio_poll_master.sv | 124 ++++++++++++
 tb/tb_bai1_pio_poll_master.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bai1_pio_pkg.sv
// Shared types and constants for the bai1 PIO poll master.
// The poller reads a single-bit input PIO through its data register.
package bai1_pio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } poll_state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         PIO_DATA_BIT  = 0;

endpackage

// File: rtl/bai1_pio_debounce.sv
// Debounces polled samples into a clean level.
// Also produces one-cycle edge pulses and a wrapping rising-edge counter.
module bai1_pio_debounce #(
  parameter int DEB_CNT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic             sample_bit,
  input  logic             clear_count,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] press_count
);

  localparam int RUN_W = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT + 1);

  logic [RUN_W-1:0] run_cnt;
  logic             flip;

  // The level flips when this sample completes a run of DEB_CNT differing samples.
  always_comb begin
    flip = sample_valid && (sample_bit != level) && (run_cnt == RUN_W'(DEB_CNT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt     <= '0;
      level       <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      press_count <= '0;
    end else begin
      rise <= flip && !level;
      fall <= flip && level;
      if (sample_valid) begin
        if ((sample_bit == level) || flip) begin
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + RUN_W'(1);
        end
      end
      if (flip) begin
        level <= ~level;
      end
      // A clear in the same cycle as a rising edge wins over the increment.
      if (clear_count) begin
        press_count <= '0;
      end else if (flip && !level) begin
        press_count <= press_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bai1_pio_poll_master.sv
// Avalon-MM read master that periodically polls the PIO data register
// and feeds bit 0 of each returned word into the debouncer.
module bai1_pio_poll_master
  import bai1_pio_pkg::*;
#(
  parameter int POLL_DIV = 50000,
  parameter int DEB_CNT  = 4,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic             avm_readdatavalid,
  input  logic [31:0]      avm_readdata,
  input  logic             clear_count,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] press_count,
  output logic             timeout_err
);

  localparam int TICK_W = $clog2(POLL_DIV);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  poll_state_t       state_q;
  poll_state_t       state_d;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [TO_W-1:0]   wait_cnt;
  logic              sample_valid;
  logic              timeout_hit;
  logic              readdata_unused;

  assign avm_address     = PIO_DATA_ADDR;
  assign readdata_unused = ^avm_readdata[31:1];
  assign tick            = enable && (tick_cnt == TICK_W'(POLL_DIV - 1));

  // Free-running poll divider, parked at zero while polling is disabled.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    avm_read     = 1'b0;
    sample_valid = 1'b0;
    timeout_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = REQ;
        end
      end
      REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (avm_readdatavalid) begin
          sample_valid = 1'b1;
          state_d      = IDLE;
        end else if (wait_cnt == TO_W'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // wait_cnt holds the number of WAIT cycles elapsed, counting the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state_q == REQ) && !avm_waitrequest) begin
        wait_cnt <= TO_W'(1);
      end else if (state_q == WAIT) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  bai1_pio_debounce #(
    .DEB_CNT(DEB_CNT),
    .CNT_W  (CNT_W)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_bit  (avm_readdata[PIO_DATA_BIT]),
    .clear_count (clear_count),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .press_count (press_count)
  );

endmodule

// File: tb/tb_bai1_pio_poll_master.sv
// Directed bench: instance A (POLL_DIV=8, DEB_CNT=3, TIMEOUT=255) and
// instance B (POLL_DIV=8, DEB_CNT=1, CNT_W=4, TIMEOUT=10) share one clock.
module tb_bai1_pio_poll_master;

  logic        clk = 1'b0;
  logic        reset;

  logic        en_a, wr_a, rdv_a, clr_a;
  logic [31:0] rd_a;
  logic [1:0]  addr_a;
  logic        read_a, level_a, rise_a, fall_a, terr_a;
  logic [15:0] press_a;

  logic        en_b, wr_b, rdv_b, clr_b;
  logic [31:0] rd_b;
  logic [1:0]  addr_b;
  logic        read_b, level_b, rise_b, fall_b, terr_b;
  logic [3:0]  press_b;

  logic pio_a, mute_a, force_a;
  logic pio_b, mute_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bai1_pio_poll_master #(.POLL_DIV(8), .DEB_CNT(3), .CNT_W(16), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wr_a), .avm_readdatavalid(rdv_a), .avm_readdata(rd_a),
    .clear_count(clr_a), .level(level_a), .rise(rise_a), .fall(fall_a),
    .press_count(press_a), .timeout_err(terr_a)
  );

  bai1_pio_poll_master #(.POLL_DIV(8), .DEB_CNT(1), .CNT_W(4), .TIMEOUT(10)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wr_b), .avm_readdatavalid(rdv_b), .avm_readdata(rd_b),
    .clear_count(clr_b), .level(level_b), .rise(rise_b), .fall(fall_b),
    .press_count(press_b), .timeout_err(terr_b)
  );

  // Advance to the next falling edge while acting as a 1-cycle-latency PIO slave:
  // a request accepted at a rising edge is answered during the following cycle.
  task automatic cycle();
    logic acc_a, acc_b;
    acc_a = read_a && !wr_a;
    acc_b = read_b && !wr_b;
    @(negedge clk);
    rdv_a = (acc_a && !mute_a) || force_a;
    rd_a  = {31'h15555555, pio_a};
    rdv_b = acc_b && !mute_b;
    rd_b  = {31'h0AAAAAAA, pio_b};
  endtask

  task automatic wait_read(input bit sel_b);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sel_b ? read_b : read_a) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL wait_read: got no avm_read within 40 cycles, required one (instance %s)", sel_b ? "B" : "A");
    end
  endtask

  task automatic wait_rdv(input bit sel_b);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (sel_b ? rdv_b : rdv_a) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL wait_rdv: got no readdatavalid within 40 cycles, required one (instance %s)", sel_b ? "B" : "A");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({read_a, addr_a, level_a, rise_a, fall_a, terr_a} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_a_bits: got %b required 0000000", {read_a, addr_a, level_a, rise_a, fall_a, terr_a});
    end
    checks++;
    if (press_a !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_a_press: got %h required 0000", press_a);
    end
    checks++;
    if ({read_b, addr_b, level_b, rise_b, fall_b, terr_b, press_b} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: got %b required 0", {read_b, addr_b, level_b, rise_b, fall_b, terr_b, press_b});
    end
    reset = 1'b0;
  endtask

  task automatic test_poll_rate();
    int n = 0;
    int last = -1;
    int bad_gap = 0;
    int bad_addr = 0;
    en_a = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      cycle();
      if (addr_a !== 2'd0) bad_addr++;
      if (read_a) begin
        n++;
        if (last >= 0 && (i - last) != 8) bad_gap++;
        last = i;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL poll_count: got %0d read cycles, required 4", n);
    end
    checks++;
    if (last != 32 || bad_gap != 0) begin
      errors++;
      $display("[TB] FAIL poll_spacing: got last read at %0d with %0d bad gaps, required 32 and 0", last, bad_gap);
    end
    checks++;
    if (bad_addr != 0) begin
      errors++;
      $display("[TB] FAIL poll_addr: got %0d non-zero address cycles, required 0", bad_addr);
    end
    checks++;
    if (level_a !== 1'b0 || press_a !== 16'h0) begin
      errors++;
      $display("[TB] FAIL poll_level: got level %b count %h, required 0 0000", level_a, press_a);
    end
  endtask

  task automatic test_debounce();
    pio_a = 1'b1;
    wait_rdv(1'b0);
    wait_rdv(1'b0);
    pio_a = 1'b0;
    wait_rdv(1'b0);
    pio_a = 1'b1;
    wait_rdv(1'b0);
    wait_rdv(1'b0);
    cycle();
    checks++;
    if (level_a !== 1'b0 || rise_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL deb_interrupted: got level %b rise %b, required 0 0", level_a, rise_a);
    end
    wait_rdv(1'b0);
    cycle();
    checks++;
    if (level_a !== 1'b1 || rise_a !== 1'b1 || fall_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL deb_rise: got level %b rise %b fall %b, required 1 1 0", level_a, rise_a, fall_a);
    end
    checks++;
    if (press_a !== 16'd1) begin
      errors++;
      $display("[TB] FAIL deb_count: got %h required 0001", press_a);
    end
    cycle();
    checks++;
    if (rise_a !== 1'b0 || level_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL deb_pulse_width: got rise %b level %b, required 0 1", rise_a, level_a);
    end
  endtask

  task automatic test_stall(input int n, input int exp_gap);
    int bad = 0;
    int gap = 0;
    wr_a = 1'b1;
    wait_read(1'b0);
    for (int i = 1; i < n; i++) begin
      cycle();
      if (read_a !== 1'b1) bad++;
    end
    cycle();
    if (read_a !== 1'b1) bad++;
    wr_a = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL stall_hold_%0d: got %0d low read cycles during stall, required 0", n, bad);
    end
    cycle();
    checks++;
    if (read_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_drop_%0d: got read %b one cycle after accept, required 0", n, read_a);
    end
    for (int i = 0; i < 20; i++) begin
      if (read_a) break;
      cycle();
      gap++;
    end
    checks++;
    if (gap != exp_gap) begin
      errors++;
      $display("[TB] FAIL stall_next_req_%0d: got %0d idle cycles, required %0d", n, gap, exp_gap);
    end
  endtask

  task automatic test_timeout();
    mute_b = 1'b1;
    en_b   = 1'b1;
    wait_read(1'b1);
    repeat (10) cycle();
    checks++;
    if (terr_b !== 1'b0 || read_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_early: got err %b read %b in 10th WAIT cycle, required 0 0", terr_b, read_b);
    end
    cycle();
    checks++;
    if (terr_b !== 1'b1 || level_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_set: got err %b level %b, required 1 0", terr_b, level_b);
    end
    mute_b = 1'b0;
    pio_b  = 1'b1;
    wait_rdv(1'b1);
    cycle();
    checks++;
    if (level_b !== 1'b1 || rise_b !== 1'b1 || press_b !== 4'd1 || terr_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_recover: got level %b rise %b count %h err %b, required 1 1 1 1", level_b, rise_b, press_b, terr_b);
    end
  endtask

  task automatic test_wrap_clear();
    for (int i = 0; i < 14; i++) begin
      pio_b = 1'b0;
      wait_rdv(1'b1);
      if (i == 0) begin
        cycle();
        checks++;
        if (fall_b !== 1'b1 || level_b !== 1'b0 || rise_b !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fall_pulse: got fall %b level %b rise %b, required 1 0 0", fall_b, level_b, rise_b);
        end
      end
      pio_b = 1'b1;
      wait_rdv(1'b1);
    end
    cycle();
    checks++;
    if (press_b !== 4'hF) begin
      errors++;
      $display("[TB] FAIL count_full: got %h required f", press_b);
    end
    pio_b = 1'b0;
    wait_rdv(1'b1);
    pio_b = 1'b1;
    wait_rdv(1'b1);
    cycle();
    checks++;
    if (press_b !== 4'h0 || rise_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL count_wrap: got count %h rise %b, required 0 1", press_b, rise_b);
    end
    pio_b = 1'b0;
    wait_rdv(1'b1);
    pio_b = 1'b1;
    wait_rdv(1'b1);
    cycle();
    checks++;
    if (press_b !== 4'h1) begin
      errors++;
      $display("[TB] FAIL count_after_wrap: got %h required 1", press_b);
    end
    pio_b = 1'b0;
    wait_rdv(1'b1);
    pio_b = 1'b1;
    wait_rdv(1'b1);
    clr_b = 1'b1;
    cycle();
    clr_b = 1'b0;
    checks++;
    if (press_b !== 4'h0 || rise_b !== 1'b1 || level_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_priority: got count %h rise %b level %b, required 0 1 1", press_b, rise_b, level_b);
    end
  endtask

  task automatic test_reset_mid_wait();
    int k = 2;
    mute_a = 1'b1;
    wait_read(1'b0);
    cycle();
    reset = 1'b1;
    cycle();
    checks++;
    if (read_a !== 1'b0 || level_a !== 1'b0 || press_a !== 16'h0 || terr_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got read %b level %b count %h err_b %b, required 0 0 0000 0", read_a, level_a, press_a, terr_b);
    end
    reset   = 1'b0;
    force_a = 1'b1;
    cycle();
    force_a = 1'b0;
    cycle();
    checks++;
    if (level_a !== 1'b0 || press_a !== 16'h0 || rise_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_late_rdv: got level %b count %h rise %b, required 0 0000 0", level_a, press_a, rise_a);
    end
    for (int i = 0; i < 20; i++) begin
      if (read_a) break;
      cycle();
      k++;
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("[TB] FAIL midreset_restart: got first read %0d cycles after reset release, required 8", k);
    end
  endtask

  initial begin
    reset = 1'b1;
    en_a = 1'b0; wr_a = 1'b0; rdv_a = 1'b0; clr_a = 1'b0; rd_a = 32'h0;
    en_b = 1'b0; wr_b = 1'b0; rdv_b = 1'b0; clr_b = 1'b0; rd_b = 32'h0;
    pio_a = 1'b0; mute_a = 1'b0; force_a = 1'b0;
    pio_b = 1'b0; mute_b = 1'b0;
    $display("[TB] starting bai1_pio_poll_master bench");
    test_reset();
    test_poll_rate();
    test_debounce();
    test_stall(5, 2);
    test_stall(10, 5);
    test_timeout();
    test_wrap_clear();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
